fir_coeff_ctrl: RTL and testbench
=================================

Name: fir_coeff_ctrl

Overview:
- Configuration and sequencing controller placed in front of one FIR engine.
- Holds a shadow coefficient bank written by a register-style port, and an active bank that drives the engine's coefficient inputs.
- On commit, it stalls upstream samples, drains in-flight samples, and swaps banks atomically at a sample boundary.
- On request, it flushes tap history by injecting zero samples and discarding their results.

Parameters:
- INPUT_TAPS, 3, number of coefficients and flush samples.
- DATA_WIDTH, 24, sample width.
- COEFF_WIDTH, 18, signed coefficient width.
- ADDR_WIDTH, $clog2(INPUT_TAPS) (min 1), coefficient address width (localparam).

Ports:
- clk_i in 1: clock.
- reset_i in 1: reset, synchronous, active-high.
- cfg_wr_i in 1: shadow write strobe.
- cfg_addr_i in ADDR_WIDTH: shadow index.
- cfg_data_i in COEFF_WIDTH: signed coefficient.
- cfg_commit_i in 1: request bank swap.
- cfg_flush_i in 1: flush tap history with this commit; sampled with cfg_commit_i.
- cfg_busy_o out 1: commit in progress.
- commit_done_o out 1: one-cycle pulse when the swap (and flush, if requested) completes.
- s_x_i in DATA_WIDTH: upstream sample.
- s_valid_i in 1: upstream valid.
- s_ready_and_o out 1: upstream ready.
- fir_x_o out DATA_WIDTH: sample to engine.
- fir_valid_o out 1: valid to engine.
- fir_ready_and_i in 1: engine ready.
- fir_coeff_o out INPUT_TAPS x COEFF_WIDTH: active bank.
- fir_y_i in DATA_WIDTH: engine result.
- fir_valid_i in 1: engine result valid.
- fir_ready_and_o out 1: ready to engine.
- m_y_o out DATA_WIDTH: downstream result.
- m_valid_o out 1: downstream valid.
- m_ready_and_i in 1: downstream ready.

Behaviour:
- Reset: state RUN; shadow and active banks all 0; inflight=0; drop=0; flush flag=0; cfg_busy_o=0; commit_done_o=0.
- Shadow write: takes effect on any edge with cfg_wr_i=1, cfg_busy_o=0 and cfg_addr_i<INPUT_TAPS. Otherwise the write is ignored.
- Write and commit in the same cycle: the write is included in that commit.
- inflight counter (2 bits):
  - +1 on fir_valid_o & fir_ready_and_i.
  - -1 on fir_valid_i & fir_ready_and_o.
  - Both in the same cycle: unchanged.
- drop counter (width $clog2(INPUT_TAPS+1)): counts flush results still to be discarded.
- Result path, all states:
  - drop>0: fir_ready_and_o=1, m_valid_o=0, and each fir_valid_i decrements drop.
  - drop=0: m_y_o=fir_y_i, m_valid_o=fir_valid_i, fir_ready_and_o=m_ready_and_i.
- RUN:
  - fir_x_o=s_x_i, fir_valid_o=s_valid_i, s_ready_and_o=fir_ready_and_i (combinational pass-through).
  - cfg_commit_i=1: latch the flush flag, set cfg_busy_o next cycle, go to DRAIN. The current-cycle handshake completes normally.
- DRAIN:
  - s_ready_and_o=0, fir_valid_o=0.
  - Leave when inflight=0, going to SWAP.
  - Downstream backpressure extends DRAIN indefinitely.
- SWAP (1 cycle):
  - active <= shadow.
  - Flush flag set: go to FLUSH.
  - Flush flag clear: go to RUN, pulse commit_done_o and clear cfg_busy_o on that edge.
- FLUSH:
  - fir_x_o=0, fir_valid_o=1, s_ready_and_o=0.
  - Each engine acceptance increments drop and a flush count.
  - After INPUT_TAPS acceptances, go to FLUSH_DRAIN.
- FLUSH_DRAIN:
  - fir_valid_o=0.
  - When drop=0 and inflight=0, go to RUN, pulse commit_done_o, clear cfg_busy_o.
- fir_coeff_o changes only in SWAP, when inflight=0. It is therefore constant across every accepted sample.
- cfg_commit_i while cfg_busy_o=1: ignored, not queued.
- Reset asserted mid-commit: returns to reset state. Shadow contents are lost; any engine output arriving afterwards passes through (drop=0).
- Commit latency with no traffic and no flush: commit_done_o 3 cycles after the commit edge (DRAIN, SWAP, RUN).

Decomposition:
- Package fir_ctrl_pkg:
  - state_t enum {RUN, DRAIN, SWAP, FLUSH, FLUSH_DRAIN}.
  - coeff_bank_t, a type parameterised via localparams shared with the FIR.
- Sub-module fir_coeff_bank: shadow/active register pair with write port and swap strobe.
- Sequencer and counters stay in the top.

Test Plan:
- Write coeffs {16384, -8192, 4096} to addrs 0..2, commit (no flush), idle stream → commit_done_o 3 cycles later; fir_coeff_o={16384,-8192,4096}; no m_valid_o activity.
- Stream continuous samples 1..20 with m_ready_and_i=1 and commit mid-stream → no sample lost or duplicated; s_ready_and_o low from the commit edge until commit_done_o; coeffs unchanged until inflight reaches 0.
- Commit with cfg_flush_i=1 after samples 100,200 → exactly 3 zero samples reach fir_x_o; their 3 results are consumed with m_valid_o=0; first post-commit output uses zeroed history.
- Hold m_ready_and_i=0 for 10 cycles during DRAIN → state stays in DRAIN and the bank is unchanged; swap occurs only after the result drains.
- Write addr 3 (out of range), and write/commit while busy → shadow unchanged, second commit ignored, single commit_done_o pulse.
- Assert reset_i during FLUSH → next cycle state RUN, cfg_busy_o=0, banks 0, drop 0.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared widths, sequencer states and coefficient bank type for the FIR controller
package fir_ctrl_pkg;
  localparam int INPUT_TAPS = 3;
  localparam int DATA_WIDTH = 24;
  localparam int COEFF_WIDTH = 18;
  localparam int ADDR_WIDTH = INPUT_TAPS > 1 ? $clog2(INPUT_TAPS) : 1;
  localparam int DROP_WIDTH = $clog2(INPUT_TAPS + 1);
  typedef enum logic [2:0] {RUN, DRAIN, SWAP, FLUSH, FLUSH_DRAIN} state_t;
  typedef logic signed [COEFF_WIDTH-1:0] coeff_t;
  typedef coeff_t [INPUT_TAPS-1:0] coeff_bank_t;
endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// fir_coeff_ctrl_if: config port, upstream/engine/downstream valid-ready streams and active coefficients; slave = controller
interface fir_coeff_ctrl_if;
  import fir_ctrl_pkg::*;
  logic cfg_wr_i;
  logic [ADDR_WIDTH-1:0] cfg_addr_i;
  coeff_t cfg_data_i;
  logic cfg_commit_i;
  logic cfg_flush_i;
  logic cfg_busy_o;
  logic commit_done_o;
  logic [DATA_WIDTH-1:0] s_x_i;
  logic s_valid_i;
  logic s_ready_and_o;
  logic [DATA_WIDTH-1:0] fir_x_o;
  logic fir_valid_o;
  logic fir_ready_and_i;
  coeff_bank_t fir_coeff_o;
  logic [DATA_WIDTH-1:0] fir_y_i;
  logic fir_valid_i;
  logic fir_ready_and_o;
  logic [DATA_WIDTH-1:0] m_y_o;
  logic m_valid_o;
  logic m_ready_and_i;
  modport slave (
    input cfg_wr_i, cfg_addr_i, cfg_data_i, cfg_commit_i, cfg_flush_i, s_x_i, s_valid_i,
          fir_ready_and_i, fir_y_i, fir_valid_i, m_ready_and_i,
    output cfg_busy_o, commit_done_o, s_ready_and_o, fir_x_o, fir_valid_o, fir_coeff_o,
           fir_ready_and_o, m_y_o, m_valid_o
  );
  modport master (
    output cfg_wr_i, cfg_addr_i, cfg_data_i, cfg_commit_i, cfg_flush_i, s_x_i, s_valid_i,
           fir_ready_and_i, fir_y_i, fir_valid_i, m_ready_and_i,
    input cfg_busy_o, commit_done_o, s_ready_and_o, fir_x_o, fir_valid_o, fir_coeff_o,
          fir_ready_and_o, m_y_o, m_valid_o
  );
endinterface

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: shadow bank written by index (out-of-range ignored), copied whole to active bank on swap_i
module fir_coeff_bank
  import fir_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic wr_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  coeff_t data_i,
  input  logic swap_i,
  output coeff_bank_t active_o
);
  coeff_bank_t shadow;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow <= '0;
      active_o <= '0;
    end else begin
      for (int i = 0; i < INPUT_TAPS; i++)
        if (wr_i && addr_i == ADDR_WIDTH'(i)) shadow[i] <= data_i;
      if (swap_i) active_o <= shadow;
    end
  end
endmodule

// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: stalls/drains the FIR engine to swap coefficient banks at a sample boundary, optionally flushing history with zeros (clk_i, reset_i, bus)
module fir_coeff_ctrl
  import fir_ctrl_pkg::*;
(
  input logic clk_i,
  input logic reset_i,
  fir_coeff_ctrl_if.slave bus
);
  state_t state, state_n;
  logic [1:0] inflight;
  logic [DROP_WIDTH-1:0] drop, flush_cnt;
  logic flush_q, done_q, push, pop, dropping, last_flush;
  coeff_bank_t active;
  assign dropping = drop != '0;
  assign push = bus.fir_valid_o & bus.fir_ready_and_i;
  assign pop = bus.fir_valid_i & bus.fir_ready_and_o;
  assign last_flush = push && flush_cnt == DROP_WIDTH'(INPUT_TAPS - 1);
  assign bus.fir_x_o = state == RUN ? bus.s_x_i : '0;
  assign bus.fir_valid_o = state == RUN ? bus.s_valid_i : state == FLUSH;
  assign bus.s_ready_and_o = state == RUN && bus.fir_ready_and_i;
  assign bus.fir_ready_and_o = dropping | bus.m_ready_and_i;
  assign bus.m_valid_o = !dropping && bus.fir_valid_i;
  assign bus.m_y_o = bus.fir_y_i;
  assign bus.cfg_busy_o = state != RUN;
  assign bus.commit_done_o = done_q;
  assign bus.fir_coeff_o = active;
  fir_coeff_bank u_bank (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .wr_i(bus.cfg_wr_i & ~bus.cfg_busy_o),
    .addr_i(bus.cfg_addr_i),
    .data_i(bus.cfg_data_i),
    .swap_i(state == SWAP),
    .active_o(active)
  );
  always_comb begin
    state_n = state;
    case (state)
      RUN: state_n = bus.cfg_commit_i ? DRAIN : RUN;
      DRAIN: state_n = inflight == '0 ? SWAP : DRAIN;
      SWAP: state_n = flush_q ? FLUSH : RUN;
      FLUSH: state_n = last_flush ? FLUSH_DRAIN : FLUSH;
      FLUSH_DRAIN: state_n = !dropping && inflight == '0 ? RUN : FLUSH_DRAIN;
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= RUN;
      inflight <= '0;
      drop <= '0;
      flush_cnt <= '0;
      flush_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= inflight + 2'(push) - 2'(pop);
      drop <= drop + DROP_WIDTH'(state == FLUSH && push) - DROP_WIDTH'(dropping && bus.fir_valid_i);
      flush_cnt <= state == SWAP ? '0 : flush_cnt + DROP_WIDTH'(state == FLUSH && push);
      if (state == RUN && bus.cfg_commit_i) flush_q <= bus.cfg_flush_i;
      done_q <= state != RUN && state_n == RUN;
    end
  end
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb_fir_coeff_ctrl: random traffic through the controller with an engine model and a queue-based scoreboard of expected FIR outputs
module tb_fir_coeff_ctrl;
  import fir_ctrl_pkg::*;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;
  fir_coeff_ctrl_if bus();
  fir_coeff_ctrl dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));
  int checks = 0, fails = 0, cyc = 0, m_out = 0, dones = 0, zcnt = 0, zexp = 0, m_mode = 0;
  bit rst_req = 1, m_busy = 0, done_seen = 0, eng_rand = 1;
  logic [DATA_WIDTH-1:0] up_q[$], exp_q[$], eng_y[$];
  int eng_due[$];
  coeff_bank_t m_shadow = '0, m_active = '0, want;
  longint m_hist[INPUT_TAPS], eng_h[INPUT_TAPS];
  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic logic [DATA_WIDTH-1:0] fir(coeff_bank_t c, longint h[INPUT_TAPS]);
    longint acc = 0;
    for (int k = 0; k < INPUT_TAPS; k++) acc += longint'(c[k]) * h[k];
    return acc[DATA_WIDTH-1:0];
  endfunction
  function automatic void reset_models();
    m_shadow = '0;
    m_active = '0;
    m_busy = 0;
    eng_y.delete();
    eng_due.delete();
    for (int k = 0; k < INPUT_TAPS; k++) begin
      m_hist[k] = 0;
      eng_h[k] = 0;
    end
  endfunction
  task automatic step(input bit wr = 0, input int addr = 0, input int data = 0, input bit commit = 0, input bit flush = 0);
    @(negedge clk_i);
    cyc++;
    done_seen = 0;
    reset_i = rst_req;
    bus.cfg_wr_i = wr;
    bus.cfg_addr_i = ADDR_WIDTH'(addr);
    bus.cfg_data_i = COEFF_WIDTH'(data);
    bus.cfg_commit_i = commit;
    bus.cfg_flush_i = flush;
    bus.s_valid_i = up_q.size() > 0 && $urandom_range(0, 3) != 0;
    bus.s_x_i = up_q.size() > 0 ? up_q[0] : '0;
    bus.fir_ready_and_i = eng_y.size() < 2 && (!eng_rand || $urandom_range(0, 3) != 0);
    bus.fir_valid_i = eng_y.size() > 0 && eng_due[0] <= cyc;
    bus.fir_y_i = eng_y.size() > 0 ? eng_y[0] : '0;
    bus.m_ready_and_i = m_mode == 0 ? 1'b1 : m_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    if (rst_req) begin
      reset_models();
      return;
    end
    if (bus.commit_done_o) begin
      dones++;
      done_seen = 1;
      check("done_only_when_busy", 64'(m_busy), 64'(1));
      check("flush_sample_count", 64'(zcnt), 64'(zexp));
      check("coeff_after_done", 64'(bus.fir_coeff_o), 64'(m_active));
      m_busy = 0;
    end
    check("busy", 64'(bus.cfg_busy_o), 64'(m_busy));
    if (m_busy) check("s_ready_while_busy", 64'(bus.s_ready_and_o), 64'(0));
    if (bus.fir_valid_o && bus.fir_ready_and_i) begin
      check("coeff_at_accept", 64'(bus.fir_coeff_o), 64'(m_active));
      if (m_busy) begin
        zcnt++;
        check("flush_sample_zero", 64'(bus.fir_x_o), 64'(0));
      end
      for (int k = INPUT_TAPS - 1; k > 0; k--) eng_h[k] = eng_h[k-1];
      eng_h[0] = longint'($signed(bus.fir_x_o));
      eng_y.push_back(fir(bus.fir_coeff_o, eng_h));
      eng_due.push_back(cyc + 2);
    end
    if (bus.fir_valid_i && bus.fir_ready_and_o) begin
      void'(eng_y.pop_front());
      void'(eng_due.pop_front());
    end
    if (bus.s_valid_i && bus.s_ready_and_o) begin
      for (int k = INPUT_TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = longint'($signed(up_q.pop_front()));
      exp_q.push_back(fir(m_active, m_hist));
    end
    if (wr && !m_busy && addr < INPUT_TAPS) m_shadow[addr] = COEFF_WIDTH'(data);
    if (commit && !m_busy) begin
      m_busy = 1;
      m_active = m_shadow;
      zcnt = 0;
      zexp = flush ? INPUT_TAPS : 0;
      if (flush) for (int k = 0; k < INPUT_TAPS; k++) m_hist[k] = 0;
    end
  endtask
  task automatic wait_done(input int budget, output int n);
    n = 0;
    done_seen = 0;
    while (!done_seen && n < budget) begin
      step();
      n++;
    end
    check("done_timeout", 64'(done_seen), 64'(1));
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while ((up_q.size() > 0 || exp_q.size() > 0 || m_busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(up_q.size() + exp_q.size()), 64'(0));
  endtask
  initial forever begin
    @(negedge clk_i);
    #2;
    if (!reset_i && bus.m_valid_o && bus.m_ready_and_i) begin
      m_out++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL m_extra: got %0h with no result expected", bus.m_y_o);
      end else check("m_y", 64'(bus.m_y_o), 64'(exp_q.pop_front()));
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, d0;
    coeff_bank_t old;
    reset_models();
    step();
    step();
    rst_req = 0;
    step();
    check("rst_state", 64'(dut.state), 64'(RUN));
    check("rst_busy", 64'(bus.cfg_busy_o), 64'(0));
    check("rst_done", 64'(bus.commit_done_o), 64'(0));
    check("rst_coeff", 64'(bus.fir_coeff_o), 64'(0));
    check("rst_drop", 64'(dut.drop), 64'(0));
    check("rst_inflight", 64'(dut.inflight), 64'(0));
    step(1, 0, 16384);
    step(1, 1, -8192);
    step(1, 2, 4096);
    step(0, 0, 0, 1, 0);
    wait_done(20, n);
    check("commit_latency", 64'(n), 64'(3));
    want[0] = 18'sd16384;
    want[1] = -18'sd8192;
    want[2] = 18'sd4096;
    check("coeff_loaded", 64'(bus.fir_coeff_o), 64'(want));
    check("no_m_activity", 64'(m_out), 64'(0));
    for (int i = 1; i <= 20; i++) up_q.push_back(DATA_WIDTH'(i));
    repeat (8) step();
    step(1, 0, 1000);
    step(0, 0, 0, 1, 0);
    wait_done(200, n);
    drain(400);
    check("stream_count", 64'(m_out), 64'(20));
    step(1, 0, 3);
    step(1, 1, -2);
    up_q.push_back(DATA_WIDTH'(100));
    up_q.push_back(DATA_WIDTH'(200));
    drain(100);
    step(1, 2, 77, 1, 1);
    wait_done(100, n);
    up_q.push_back(DATA_WIDTH'(300));
    up_q.push_back(DATA_WIDTH'(400));
    drain(100);
    check("flush_out_count", 64'(m_out), 64'(24));
    eng_rand = 0;
    m_mode = 2;
    up_q.push_back(DATA_WIDTH'(5));
    up_q.push_back(DATA_WIDTH'(6));
    repeat (6) step();
    old = m_active;
    step(1, 1, 555);
    step(0, 0, 0, 1, 0);
    repeat (10) begin
      step();
      check("drain_hold_state", 64'(dut.state), 64'(DRAIN));
      check("drain_hold_bank", 64'(bus.fir_coeff_o), 64'(old));
    end
    m_mode = 0;
    eng_rand = 1;
    wait_done(100, n);
    drain(100);
    m_mode = 1;
    d0 = dones;
    step(1, 3, 777);
    step(0, 0, 0, 1, 0);
    step(1, 0, 5, 1, 0);
    wait_done(100, n);
    repeat (10) step();
    check("single_done", 64'(dones - d0), 64'(1));
    for (int t = 0; t < 400; t++) begin
      if (up_q.size() < 4 && $urandom_range(0, 1) == 1) up_q.push_back(DATA_WIDTH'($urandom));
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 262143)) - 131072,
           $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1);
    end
    drain(400);
    step(1, 0, 9);
    step(0, 0, 0, 1, 1);
    n = 0;
    while (dut.state != FLUSH && n < 30) begin
      step();
      n++;
    end
    check("reach_flush", 64'(dut.state), 64'(FLUSH));
    rst_req = 1;
    step();
    rst_req = 0;
    step();
    check("midrst_state", 64'(dut.state), 64'(RUN));
    check("midrst_busy", 64'(bus.cfg_busy_o), 64'(0));
    check("midrst_coeff", 64'(bus.fir_coeff_o), 64'(0));
    check("midrst_drop", 64'(dut.drop), 64'(0));
    step(1, 0, 2);
    step(0, 0, 0, 1, 0);
    wait_done(50, n);
    for (int i = 7; i <= 10; i++) up_q.push_back(DATA_WIDTH'(i));
    drain(100);
    repeat (5) step();
    check("final_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
